// File: rtl/rv_pkg.sv
// Shared RV32M definitions for the multi-cycle multiply/divide unit: op encoding,
// width and the architectural divide-by-zero / overflow constants.
package rv_pkg;
   localparam int XLEN = 32;

   // funct3 encoding of the M extension
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } mdu_op_e;

   localparam logic [XLEN-1:0] DIV0_RESULT = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] INT_MIN     = 32'h8000_0000;

   function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? -v : v;
   endfunction
endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration, purely combinational: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module mdu_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic         dividend_bit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic         quo_bit
);
   logic [W:0]   shifted;
   logic [W-1:0] diff;

   always_comb begin
      shifted  = {rem, dividend_bit};
      quo_bit  = (shifted >= {1'b0, divisor});
      // When the subtraction is kept the true difference is below the divisor, so W bits suffice
      diff     = shifted[W-1:0] - divisor;
      rem_next = quo_bit ? diff : shifted[W-1:0];
   end
endmodule

// File: rtl/mdu_seq.sv
// RV32M multiply/divide unit, one bit per cycle (33-cycle latency, 1 for div-by-0/overflow);
// result holds under rsp_ready backpressure. MDU_FAST_MUL_EN selects a 2-cycle combinational multiply.
module mdu_seq
   import rv_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  mdu_op_e         req_op,
   input  logic [XLEN-1:0] oprnd_a,
   input  logic [XLEN-1:0] oprnd_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   mdu_op_e           op;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [XLEN-1:0]   mcand;    // multiplicand or divisor
   logic              neg_res;
   logic              neg_rem;
   logic [XLEN-1:0]   result;

   logic              a_sgn, b_sgn, div0, ovf, done_now;
   logic [XLEN-1:0]   a_abs, b_abs, special_res, fin_res, quo, remv;
   logic [2*XLEN-1:0] acc_nxt, fin_acc, prod_s;
   logic [XLEN:0]     sum;
   logic [XLEN-1:0]   rem_next;
   logic              quo_bit;

   mdu_div_step #(.W(XLEN)) u_div_step (
      .rem          (acc[2*XLEN-1:XLEN]),
      .dividend_bit (acc[XLEN-1]),
      .divisor      (mcand),
      .rem_next     (rem_next),
      .quo_bit      (quo_bit)
   );

`ifdef MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
   always_comb begin
      a_ext     = (req_op == MULH || req_op == MULHSU) ? {{XLEN{oprnd_a[XLEN-1]}}, oprnd_a}
                                                       : {{XLEN{1'b0}}, oprnd_a};
      b_ext     = (req_op == MULH) ? {{XLEN{oprnd_b[XLEN-1]}}, oprnd_b} : {{XLEN{1'b0}}, oprnd_b};
      fast_prod = a_ext * b_ext;
   end
`endif

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (req_op)
         MULH:     begin a_sgn = 1'b1; b_sgn = 1'b1; end
         MULHSU:   a_sgn = 1'b1;
         DIV, REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
         default:  ;
      endcase
      a_abs       = abs_if(oprnd_a, a_sgn);
      b_abs       = abs_if(oprnd_b, b_sgn);
      div0        = req_op[2] && (oprnd_b == '0);
      ovf         = (req_op == DIV || req_op == REM) && (oprnd_a == INT_MIN) && (oprnd_b == '1);
      special_res = div0 ? (req_op[1] ? oprnd_a : DIV0_RESULT)
                         : (req_op[1] ? '0 : INT_MIN);
   end

   always_comb begin
      sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
      if (op[2])
         acc_nxt = {rem_next, acc[XLEN-2:0], quo_bit};
      else
         acc_nxt = {sum, acc[XLEN-1:1]};

      fin_acc  = acc_nxt;
      done_now = (state == S_CALC) && (cnt == CNT_W'(XLEN-1));
`ifdef MDU_FAST_MUL_EN
      // The fast product was already loaded on the accept edge and needs no sign fix-up
      if (!op[2]) begin
         fin_acc  = acc;
         done_now = (state == S_CALC);
      end
`endif
      prod_s = neg_res ? -fin_acc : fin_acc;
      quo    = neg_res ? -fin_acc[XLEN-1:0] : fin_acc[XLEN-1:0];
      remv   = neg_rem ? -fin_acc[2*XLEN-1:XLEN] : fin_acc[2*XLEN-1:XLEN];
      case (op)
         MUL:                 fin_res = prod_s[XLEN-1:0];
         MULH, MULHSU, MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
         DIV, DIVU:           fin_res = quo;
         default:             fin_res = remv;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         op      <= MUL;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op      <= req_op;
                  cnt     <= '0;
                  mcand   <= b_abs;
                  neg_res <= (a_sgn & oprnd_a[XLEN-1]) ^ (b_sgn & oprnd_b[XLEN-1]);
                  neg_rem <= a_sgn & oprnd_a[XLEN-1];
                  acc     <= {{XLEN{1'b0}}, a_abs};
                  if (div0 || ovf) begin
                     result <= special_res;
                     state  <= S_DONE;
                  end else begin
                     state  <= S_CALC;
`ifdef MDU_FAST_MUL_EN
                     if (!req_op[2]) begin
                        acc     <= fast_prod;
                        neg_res <= 1'b0;
                     end
`endif
                  end
               end
            end
            S_CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (done_now) begin
                  result <= fin_res;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (rsp_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign rsp_valid  = (state == S_DONE);
   assign rsp_result = result;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed table-driven bench for mdu_seq plus backpressure and mid-operation reset sequences.
module tb_mdu_seq;
   import rv_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   mdu_op_e     req_op;
   logic [31:0] oprnd_a;
   logic [31:0] oprnd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdu_seq dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .oprnd_a    (oprnd_a),
      .oprnd_b    (oprnd_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   typedef struct {
      mdu_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request, measure accept-to-valid latency, compare result, then complete the handshake.
   task automatic run_op(input vec_t v, input string name);
      int n;
      @(negedge clk);
      chk({name, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = v.op;
      oprnd_a   = v.a;
      oprnd_b   = v.b;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({name, " rsp_valid seen"}, 32'(rsp_valid), 32'd1);
      chk({name, " latency"}, 32'(n), 32'(v.lat));
      chk({name, " result"}, rsp_result, v.exp);
      chk({name, " req_ready in DONE"}, 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({name, " back to idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      int n;
      logic seen;
      vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
      vecs[1]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
      vecs[2]  = '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
      vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
      vecs[4]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
      vecs[5]  = '{MULHU,  32'h8000_0000,  32'd2,         32'h0000_0001, MUL_LAT};
      vecs[6]  = '{DIVU,   32'd100,        32'd7,         32'd14,        33};
      vecs[7]  = '{REMU,   32'd100,        32'd7,         32'd2,         33};
      vecs[8]  = '{DIV,    32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 33};
      vecs[9]  = '{REM,    32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 33};
      vecs[10] = '{DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[11] = '{REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33};
      vecs[12] = '{DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 33};
      vecs[13] = '{DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
      vecs[14] = '{REM,    32'h1234_5678,  32'd0,         32'h1234_5678, 1};
      vecs[15] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[16] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[17] = '{REMU,   32'hCAFE_0001,  32'd0,         32'hCAFE_0001, 1};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = MUL;
      oprnd_a   = '0;
      oprnd_b   = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset req_ready",  32'(req_ready),  32'd1);
      chk("reset rsp_valid",  32'(rsp_valid),  32'd0);
      chk("reset busy",       32'(busy),       32'd0);
      chk("reset rsp_result", rsp_result,      32'd0);

      for (int i = 0; i < 18; i++)
         run_op(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: request held high through DONE must not be re-accepted.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = DIVU;
      oprnd_a   = 32'd100;
      oprnd_b   = 32'd7;
      @(posedge clk);
      #1 req_op = MULHU;
      oprnd_a = 32'hFFFF_FFFF;
      oprnd_b = 32'hFFFF_FFFF;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp rsp_valid seen", 32'(rsp_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp result hold", rsp_result, 32'd14);
         chk("bp ready low", {30'd0, req_ready, rsp_valid}, 32'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("bp idle after handshake", {30'd0, req_ready, rsp_valid}, 32'd2);
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("bp new accept", {31'd0, busy}, 32'd1);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp second result", rsp_result, 32'hFFFF_FFFE);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // Reset during iteration 15 of a DIVU abandons it silently.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = DIVU;
      oprnd_a   = 32'hFFFF_FFFF;
      oprnd_b   = 32'd1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst mid req_ready",  32'(req_ready), 32'd1);
      chk("rst mid rsp_valid",  32'(rsp_valid), 32'd0);
      chk("rst mid busy",       32'(busy),      32'd0);
      chk("rst mid rsp_result", rsp_result,     32'd0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("rst mid no response", 32'(seen), 32'd0);
      run_op('{DIVU, 32'd9, 32'd3, 32'd3, 33}, "post-reset divu");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
